barrel_dispenser: RTL and testbench
===================================

// Module: barrel_dispenser
// PURPOSE
//   Sits directly downstream of the Kong controller. Detects Kong's HOLD->DROP
//   animation step, picks a free barrel slot from a fixed pool, and offers a
//   spawn request (slot id + start position) to the barrel movers over a
//   valid/ready handshake. Tracks which slots are alive and counts barrels thrown.
// PARAMETERS
//   N_BARRELS   8    pool size, 1..16; slot ids are 0..N_BARRELS-1
//   ID_W        3    slot id width, equal to clog2(N_BARRELS)
//   X_OFFSET    40   spawn x offset added to kong_x (10-bit)
//   Y_OFFSET    30   spawn y offset added to kong_y (9-bit)
//   COOLDOWN    16   minimum clocks between accepted spawns (COOLDOWN_EN only)
// PORTS
//   clk            in   1          system clock
//   rst_n          in   1          asynchronous reset, active low
//   kong_state     in   1          0 = initial, 1 = playing
//   kong_anim      in   2          00 normal, 01 get, 10 hold, 11 drop
//   kong_x         in   10         Kong x position
//   kong_y         in   9          Kong y position
//   spawn_ready    in   1          barrel mover accepts the offered spawn
//   despawn_valid  in   1          a barrel left the screen or was destroyed
//   despawn_id     in   ID_W       slot freed by despawn_valid
//   spawn_valid    out  1          a spawn offer is pending
//   spawn_id       out  ID_W       slot being spawned
//   spawn_x        out  10         (kong_x + X_OFFSET) mod 1024
//   spawn_y        out  9          (kong_y + Y_OFFSET) mod 512
//   active_mask    out  N_BARRELS  bit i = 1 while slot i is alive
//   thrown_count   out  8          barrels accepted this round, saturates at 255
//   miss_count     out  8          drop events discarded this round, saturates at 255
// BEHAVIOUR
//   Reset (rst_n = 0, asynchronous): all outputs 0. FSM goes to IDLE. prev_anim = 00.
//   Drop event: registered prev_anim == 10, current kong_anim == 11, kong_state == 1.
//     The event is a single-cycle pulse. It fires once per HOLD->DROP edge.
//   Free slots: ~active_mask. The slot reserved by a pending offer is not free.
//     The allocator always picks the lowest free index.
//   FSM states:
//     IDLE  : on a drop event with a free slot, latch the slot, spawn_x and spawn_y.
//             Next cycle spawn_valid = 1 and the FSM enters OFFER.
//             On a drop event with no free slot: miss_count++ and stay in IDLE.
//     OFFER : spawn_valid, spawn_id, spawn_x and spawn_y stay stable until
//             spawn_valid & spawn_ready.
//             On handshake: set active_mask[id], thrown_count++, go to IDLE
//             (or COOLDOWN). spawn_valid drops the next cycle.
//             A drop event during OFFER: miss_count++. The offer is unaffected.
//   Despawn: despawn_valid clears active_mask[despawn_id] the next cycle.
//     A despawn of an inactive slot, or of an id >= N_BARRELS, is ignored.
//     A despawn in the same cycle as a handshake on a different id: both apply.
//     A freed slot can be allocated by a drop event in the following cycle.
//   Round end (kong_state = 0): active_mask is cleared the next cycle.
//     Any pending offer is withdrawn: spawn_valid = 0 and the FSM goes to IDLE,
//     even without a handshake. Drop events are ignored.
//   Round start (kong_state rising 0->1): thrown_count and miss_count clear to 0.
//   A drop event coinciding with the round-start edge is accepted.
//   Latency: drop event to spawn_valid = 1 clock. Handshake to active_mask = 1 clock.
// CONFIGURATION
//   DISPENSER_COOLDOWN_EN defined:
//     After each handshake the FSM enters COOLDOWN for COOLDOWN clocks
//     (counter width 8). It then returns to IDLE.
//     Drop events during COOLDOWN: miss_count++.
//     Round end aborts COOLDOWN and returns to IDLE.
//   DISPENSER_COOLDOWN_EN undefined:
//     No COOLDOWN state. The handshake returns directly to IDLE.
//     Back-to-back spawns are limited only by the handshake.
// TESTING
//   1 Reset, kong_state=1, anim 00->10->11, kong_x=150, kong_y=150, ready=1
//     -> spawn_valid 1 clk after drop; id=0, x=190, y=180;
//     next cycle active_mask=0x01, thrown_count=1.
//   2 Hold spawn_ready=0 for 5 clks while issuing a second drop
//     -> offer stays stable with id=0; miss_count=1; after ready=1, thrown_count=1.
//   3 Fill all 8 slots, then issue a 9th drop -> no spawn_valid, miss_count=1.
//     Then despawn_id=3 and drop again -> spawn_id=3, active_mask=0xFF.
//   4 OFFER pending, then kong_state->0 -> spawn_valid=0 and active_mask=0 next clk.
//     Then kong_state->1 -> both counters read 0.
//   5 Assert rst_n=0 mid-OFFER, asynchronously between clock edges
//     -> all outputs 0 immediately, without waiting for a clock edge.
//   6 (COOLDOWN_EN, COOLDOWN=16) drop 5 clks after a handshake -> miss_count++.
//     A drop 17 clks after the handshake -> spawns normally.

Source files
------------

// File: rtl/barrel_dispenser_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// barrel_dispenser_if : spawn offer / despawn bus between dispenser and movers
// Revision 1.0
// ---------------------------------------------------------------------------
interface barrel_dispenser_if #(
  parameter int ID_W = 3
);
  logic            spawn_valid;
  logic            spawn_ready;
  logic [ID_W-1:0] spawn_id;
  logic [9:0]      spawn_x;
  logic [8:0]      spawn_y;
  logic            despawn_valid;
  logic [ID_W-1:0] despawn_id;

  modport master (
    output spawn_valid, spawn_id, spawn_x, spawn_y,
    input  spawn_ready, despawn_valid, despawn_id
  );

  modport slave (
    input  spawn_valid, spawn_id, spawn_x, spawn_y,
    output spawn_ready, despawn_valid, despawn_id
  );
endinterface
`default_nettype wire

// File: rtl/barrel_dispenser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// barrel_dispenser : turns Kong HOLD->DROP steps into barrel spawn offers
// Optional post-spawn cooldown enabled by DISPENSER_COOLDOWN_EN. Revision 1.0
// ---------------------------------------------------------------------------
module barrel_dispenser #(
  parameter int N_BARRELS = 8,
  parameter int ID_W      = 3,
  parameter int X_OFFSET  = 40,
  parameter int Y_OFFSET  = 30
`ifdef DISPENSER_COOLDOWN_EN
  ,
  parameter int COOLDOWN  = 16
`endif
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 kong_state_i,
  input  wire logic [1:0]           kong_anim_i,
  input  wire logic [9:0]           kong_x_i,
  input  wire logic [8:0]           kong_y_i,
  barrel_dispenser_if.master        bus,
  output logic [N_BARRELS-1:0]      active_mask_o,
  output logic [7:0]                thrown_count_o,
  output logic [7:0]                miss_count_o
);

  localparam int DEC_W = 1 << ID_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_COOL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            prev_anim_q;
  logic                  kong_state_q;
  logic [ID_W-1:0]       spawn_id_q, spawn_id_d;
  logic [9:0]            spawn_x_q, spawn_x_d;
  logic [8:0]            spawn_y_q, spawn_y_d;
  logic [N_BARRELS-1:0]  active_q, active_d;
  logic [7:0]            thrown_q, thrown_d;
  logic [7:0]            miss_q, miss_d;
`ifdef DISPENSER_COOLDOWN_EN
  logic [7:0]            cool_q, cool_d;
`endif

  logic                  drop_ev;
  logic                  round_start;
  logic                  hs;
  logic                  free_found;
  logic [ID_W-1:0]       free_id;
  logic [DEC_W-1:0]      dsp_dec;
  logic [DEC_W-1:0]      set_dec;
  logic [N_BARRELS-1:0]  dsp_clr;

  assign drop_ev     = (prev_anim_q == 2'b10) && (kong_anim_i == 2'b11) && kong_state_i;
  assign round_start = kong_state_i && !kong_state_q;
  assign hs          = (state_q == S_OFFER) && bus.spawn_ready && kong_state_i;

  // Decoding into a power-of-two vector drops out-of-range ids for free.
  assign dsp_dec = DEC_W'(1) << bus.despawn_id;
  assign set_dec = DEC_W'(1) << spawn_id_q;
  assign dsp_clr = bus.despawn_valid ? dsp_dec[N_BARRELS-1:0] : '0;

  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = N_BARRELS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_id    = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    spawn_id_d = spawn_id_q;
    spawn_x_d  = spawn_x_q;
    spawn_y_d  = spawn_y_q;
    active_d   = active_q & ~dsp_clr;
    thrown_d   = thrown_q;
    miss_d     = miss_q;
`ifdef DISPENSER_COOLDOWN_EN
    cool_d     = cool_q;
`endif

    if (round_start) begin
      thrown_d = 8'd0;
      miss_d   = 8'd0;
    end

    case (state_q)
      S_IDLE: begin
        if (drop_ev) begin
          if (free_found) begin
            state_d    = S_OFFER;
            spawn_id_d = free_id;
            spawn_x_d  = kong_x_i + 10'(X_OFFSET);
            spawn_y_d  = kong_y_i + 9'(Y_OFFSET);
          end else if (miss_d != 8'hFF) begin
            miss_d = miss_d + 8'd1;
          end
        end
      end
      S_OFFER: begin
        if (drop_ev && (miss_d != 8'hFF)) begin
          miss_d = miss_d + 8'd1;
        end
        if (hs) begin
          active_d = active_d | set_dec[N_BARRELS-1:0];
          if (thrown_d != 8'hFF) begin
            thrown_d = thrown_d + 8'd1;
          end
`ifdef DISPENSER_COOLDOWN_EN
          if (COOLDOWN == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_COOL;
            cool_d  = 8'(COOLDOWN - 1);
          end
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef DISPENSER_COOLDOWN_EN
      S_COOL: begin
        if (drop_ev && (miss_d != 8'hFF)) begin
          miss_d = miss_d + 8'd1;
        end
        if (cool_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          cool_d = cool_q - 8'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Round end wins over everything: withdraw the offer and free the pool.
    if (!kong_state_i) begin
      state_d  = S_IDLE;
      active_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      prev_anim_q  <= 2'b00;
      kong_state_q <= 1'b0;
      spawn_id_q   <= '0;
      spawn_x_q    <= '0;
      spawn_y_q    <= '0;
      active_q     <= '0;
      thrown_q     <= 8'd0;
      miss_q       <= 8'd0;
`ifdef DISPENSER_COOLDOWN_EN
      cool_q       <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      prev_anim_q  <= kong_anim_i;
      kong_state_q <= kong_state_i;
      spawn_id_q   <= spawn_id_d;
      spawn_x_q    <= spawn_x_d;
      spawn_y_q    <= spawn_y_d;
      active_q     <= active_d;
      thrown_q     <= thrown_d;
      miss_q       <= miss_d;
`ifdef DISPENSER_COOLDOWN_EN
      cool_q       <= cool_d;
`endif
    end
  end

  assign bus.spawn_valid = (state_q == S_OFFER);
  assign bus.spawn_id    = spawn_id_q;
  assign bus.spawn_x     = spawn_x_q;
  assign bus.spawn_y     = spawn_y_q;
  assign active_mask_o   = active_q;
  assign thrown_count_o  = thrown_q;
  assign miss_count_o    = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_barrel_dispenser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_barrel_dispenser : directed scoreboard bench for barrel_dispenser
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_barrel_dispenser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       kong_state;
  logic [1:0] kong_anim;
  logic [9:0] kong_x;
  logic [8:0] kong_y;
  logic [7:0] active_mask;
  logic [7:0] thrown;
  logic [7:0] miss;

  int checks   = 0;
  int failures = 0;

  logic [21:0] sb_q[$];

  always #5 clk = ~clk;

  barrel_dispenser_if #(.ID_W(3)) bif ();

  barrel_dispenser dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .kong_state_i   (kong_state),
    .kong_anim_i    (kong_anim),
    .kong_x_i       (kong_x),
    .kong_y_i       (kong_y),
    .bus            (bif),
    .active_mask_o  (active_mask),
    .thrown_count_o (thrown),
    .miss_count_o   (miss)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] pack(input logic [2:0] id, input logic [9:0] x, input logic [8:0] y);
    return {id, x, y};
  endfunction

  // Inputs are set in the low phase; the handshake seen here is what the next edge samples.
  task automatic step();
    logic [21:0] got;
    if (bif.spawn_valid && bif.spawn_ready) begin
      got = {bif.spawn_id, bif.spawn_x, bif.spawn_y};
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_spawn", 32'(got), 32'hFFFF_FFFF);
      end else begin
        chk("sb_spawn", 32'(got), 32'(sb_q.pop_front()));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drop();
    kong_anim = 2'b10;
    step();
    kong_anim = 2'b11;
    step();
    kong_anim = 2'b00;
  endtask

  task automatic cool_wait();
`ifdef DISPENSER_COOLDOWN_EN
    repeat (16) step();
`endif
  endtask

  task automatic do_reset();
    kong_anim = 2'b00;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n              = 1'b0;
    kong_state         = 1'b0;
    kong_anim          = 2'b00;
    kong_x             = 10'd0;
    kong_y             = 9'd0;
    bif.spawn_ready    = 1'b0;
    bif.despawn_valid  = 1'b0;
    bif.despawn_id     = 3'd0;
    repeat (2) @(negedge clk);

    chk("rst_valid",  32'(bif.spawn_valid), 32'd0);
    chk("rst_bus",    32'({bif.spawn_id, bif.spawn_x, bif.spawn_y}), 32'd0);
    chk("rst_mask",   32'(active_mask), 32'd0);
    chk("rst_thrown", 32'(thrown), 32'd0);
    chk("rst_miss",   32'(miss), 32'd0);
    rst_n = 1'b1;
    step();

    // 1: basic spawn
    kong_state      = 1'b1;
    kong_x          = 10'd150;
    kong_y          = 9'd150;
    bif.spawn_ready = 1'b1;
    step();
    sb_q.push_back(pack(3'd0, 10'd190, 9'd180));
    drop();
    chk("t1_valid", 32'(bif.spawn_valid), 32'd1);
    chk("t1_id",    32'(bif.spawn_id), 32'd0);
    chk("t1_x",     32'(bif.spawn_x), 32'd190);
    chk("t1_y",     32'(bif.spawn_y), 32'd180);
    step();
    chk("t1_valid_low", 32'(bif.spawn_valid), 32'd0);
    chk("t1_mask",      32'(active_mask), 32'h01);
    chk("t1_thrown",    32'(thrown), 32'd1);
    cool_wait();

    // 2: back-pressure with a drop during OFFER
    do_reset();
    bif.spawn_ready = 1'b0;
    sb_q.push_back(pack(3'd0, 10'd190, 9'd180));
    drop();
    chk("t2_valid", 32'(bif.spawn_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      kong_anim = (i == 1) ? 2'b10 : ((i == 2) ? 2'b11 : 2'b00);
      step();
      chk("t2_hold_valid", 32'(bif.spawn_valid), 32'd1);
      chk("t2_hold_bus",   32'({bif.spawn_id, bif.spawn_x, bif.spawn_y}),
                           32'(pack(3'd0, 10'd190, 9'd180)));
    end
    kong_anim = 2'b00;
    chk("t2_miss",      32'(miss), 32'd1);
    chk("t2_thrown_0",  32'(thrown), 32'd0);
    bif.spawn_ready = 1'b1;
    step();
    chk("t2_thrown_1",  32'(thrown), 32'd1);
    chk("t2_mask",      32'(active_mask), 32'h01);
    cool_wait();

    // 3: fill the pool, overflow, despawn and reuse
    do_reset();
    bif.spawn_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sb_q.push_back(pack(3'(i), 10'd190, 9'd180));
      drop();
      step();
      cool_wait();
    end
    chk("t3_mask_full", 32'(active_mask), 32'hFF);
    chk("t3_thrown8",   32'(thrown), 32'd8);
    drop();
    chk("t3_no_valid",  32'(bif.spawn_valid), 32'd0);
    chk("t3_miss",      32'(miss), 32'd1);
    bif.despawn_valid = 1'b1;
    bif.despawn_id    = 3'd3;
    step();
    bif.despawn_valid = 1'b0;
    chk("t3_mask_f7",   32'(active_mask), 32'hF7);
    sb_q.push_back(pack(3'd3, 10'd190, 9'd180));
    drop();
    chk("t3_valid",     32'(bif.spawn_valid), 32'd1);
    chk("t3_id3",       32'(bif.spawn_id), 32'd3);
    bif.despawn_valid = 1'b1;
    bif.despawn_id    = 3'd5;
    step();
    chk("t3_mask_df",   32'(active_mask), 32'hDF);
    chk("t3_thrown9",   32'(thrown), 32'd9);
    step();
    bif.despawn_valid = 1'b0;
    chk("t3_dsp_inactive", 32'(active_mask), 32'hDF);
    cool_wait();

    // 4: round end withdraws the offer, round start clears counters
    bif.spawn_ready = 1'b0;
    drop();
    chk("t4_valid", 32'(bif.spawn_valid), 32'd1);
    chk("t4_id5",   32'(bif.spawn_id), 32'd5);
    kong_state = 1'b0;
    step();
    chk("t4_withdraw",  32'(bif.spawn_valid), 32'd0);
    chk("t4_mask_clr",  32'(active_mask), 32'h00);
    chk("t4_thrown_hold", 32'(thrown), 32'd9);
    chk("t4_miss_hold", 32'(miss), 32'd1);
    drop();
    chk("t4_ignored_valid", 32'(bif.spawn_valid), 32'd0);
    chk("t4_ignored_miss",  32'(miss), 32'd1);
    kong_x    = 10'd1000;
    kong_y    = 9'd500;
    kong_anim = 2'b10;
    step();
    kong_state      = 1'b1;
    kong_anim       = 2'b11;
    bif.spawn_ready = 1'b1;
    sb_q.push_back(pack(3'd0, 10'd16, 9'd18));
    step();
    kong_anim = 2'b00;
    chk("t4_thrown_clr", 32'(thrown), 32'd0);
    chk("t4_miss_clr",   32'(miss), 32'd0);
    chk("t4_edge_valid", 32'(bif.spawn_valid), 32'd1);
    chk("t4_wrap_bus",   32'({bif.spawn_id, bif.spawn_x, bif.spawn_y}),
                         32'(pack(3'd0, 10'd16, 9'd18)));
    step();
    chk("t4_thrown1", 32'(thrown), 32'd1);
    chk("t4_mask1",   32'(active_mask), 32'h01);
    cool_wait();

    // 5: asynchronous reset mid-OFFER
    kong_x          = 10'd150;
    kong_y          = 9'd150;
    bif.spawn_ready = 1'b0;
    drop();
    chk("t5_valid", 32'(bif.spawn_valid), 32'd1);
    chk("t5_id1",   32'(bif.spawn_id), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid0",  32'(bif.spawn_valid), 32'd0);
    chk("t5_bus0",    32'({bif.spawn_id, bif.spawn_x, bif.spawn_y}), 32'd0);
    chk("t5_mask0",   32'(active_mask), 32'd0);
    chk("t5_thrown0", 32'(thrown), 32'd0);
    chk("t5_miss0",   32'(miss), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

`ifdef DISPENSER_COOLDOWN_EN
    // 6: drops inside and after the cooldown window
    bif.spawn_ready = 1'b1;
    step();
    sb_q.push_back(pack(3'd0, 10'd190, 9'd180));
    drop();
    step();
    repeat (3) step();
    drop();
    chk("t6_cool_valid", 32'(bif.spawn_valid), 32'd0);
    chk("t6_cool_miss",  32'(miss), 32'd1);
    repeat (10) step();
    sb_q.push_back(pack(3'd1, 10'd190, 9'd180));
    drop();
    chk("t6_after_valid", 32'(bif.spawn_valid), 32'd1);
    chk("t6_after_id",    32'(bif.spawn_id), 32'd1);
    step();
    chk("t6_thrown2",     32'(thrown), 32'd2);
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
